tick_scheduler: RTL and testbench

- Central game-timing controller. Generates the single-cycle enable ticks that pace enemy tanks, the player tank and bullets, all from one shared prescaler.
- Sequences the game run/pause/stop states and owns the "faster" power-up. The power-up has a timed duration and a seconds-remaining countdown for the HUD.
- Sits between the game-state logic (start/stop/pause/item events) and every motion block that consumes ticks.

---
 rtl/tick_scheduler_if.sv | 47 ++++
 rtl/tick_scheduler.sv | 157 +++++++++++++++
 tb/tb_tick_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// Event/tick bundle between the game-state logic (master) and tick_scheduler (slave).
// Optional level-clock outputs are present only when LEVEL_OUT_EN is defined.
interface tick_scheduler_if;
  logic       start;
  logic       stop;
  logic       pause_toggle;
  logic       item_faster_grant;
  logic       tick_2Hz;
  logic       tick_4Hz;
  logic       tick_8Hz;
  logic       tick_1Hz;
  logic       faster_active;
  logic [3:0] faster_remain;
  logic       running;
  logic       paused;
`ifdef LEVEL_OUT_EN
  logic       lvl_2Hz;
  logic       lvl_4Hz;
  logic       lvl_8Hz;

  modport master (
    output start, stop, pause_toggle, item_faster_grant,
    input  tick_2Hz, tick_4Hz, tick_8Hz, tick_1Hz,
    input  faster_active, faster_remain, running, paused,
    input  lvl_2Hz, lvl_4Hz, lvl_8Hz
  );

  modport slave (
    input  start, stop, pause_toggle, item_faster_grant,
    output tick_2Hz, tick_4Hz, tick_8Hz, tick_1Hz,
    output faster_active, faster_remain, running, paused,
    output lvl_2Hz, lvl_4Hz, lvl_8Hz
  );
`else
  modport master (
    output start, stop, pause_toggle, item_faster_grant,
    input  tick_2Hz, tick_4Hz, tick_8Hz, tick_1Hz,
    input  faster_active, faster_remain, running, paused
  );

  modport slave (
    input  start, stop, pause_toggle, item_faster_grant,
    output tick_2Hz, tick_4Hz, tick_8Hz, tick_1Hz,
    output faster_active, faster_remain, running, paused
  );
`endif
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler, 4-bit phase and run/pause/faster sequencing
// that produces the single-cycle motion ticks for the game.
// Optional macro LEVEL_OUT_EN adds 50%-duty level copies of phase[2:0].
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | game stopped, counters cleared, no ticks
// S_RUN   | counting, normal player speed
// S_FAST  | counting, faster power-up active, faster_remain counting down
// S_PAUSE | counters frozen; held remembers whether FAST was interrupted
module tick_scheduler #(
  parameter int BASE_DIV  = 6250000,
  parameter int ITEM_SECS = 10
) (
  input  logic clk,
  input  logic rst,
  tick_scheduler_if.slave bus
);

  localparam int PW = $clog2(BASE_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAST, S_PAUSE} state_t;

  state_t          state;
  logic            held;
  logic [PW-1:0]   presc;
  logic [3:0]      phase;
  logic [3:0]      remain;
  logic            t2, t4, t8, t1;
  logic            fa, run_q, pause_q;
`ifdef LEVEL_OUT_EN
  logic            l2, l4, l8;
`endif

  logic            base_pulse;
  logic [3:0]      phase_inc;

  assign base_pulse = (presc == PW'(BASE_DIV - 1));
  assign phase_inc  = phase + 4'd1;

  // Sequencer, prescaler, phase and registered tick/status outputs.
  // The cycle that enters PAUSE does not advance the counters, so no tick can
  // land in the first PAUSE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      held    <= 1'b0;
      presc   <= '0;
      phase   <= 4'd0;
      remain  <= 4'd0;
      t2      <= 1'b0;
      t4      <= 1'b0;
      t8      <= 1'b0;
      t1      <= 1'b0;
      fa      <= 1'b0;
      run_q   <= 1'b0;
      pause_q <= 1'b0;
`ifdef LEVEL_OUT_EN
      l2      <= 1'b0;
      l4      <= 1'b0;
      l8      <= 1'b0;
`endif
    end else begin
      t2 <= 1'b0;
      t4 <= 1'b0;
      t8 <= 1'b0;
      t1 <= 1'b0;
      if (bus.stop) begin
        state   <= S_IDLE;
        held    <= 1'b0;
        presc   <= '0;
        phase   <= 4'd0;
        remain  <= 4'd0;
        fa      <= 1'b0;
        run_q   <= 1'b0;
        pause_q <= 1'b0;
`ifdef LEVEL_OUT_EN
        l2      <= 1'b0;
        l4      <= 1'b0;
        l8      <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state <= S_RUN;
              presc <= '0;
              phase <= 4'd0;
              run_q <= 1'b1;
            end
          end
          S_PAUSE: begin
            if (bus.pause_toggle) begin
              state   <= held ? S_FAST : S_RUN;
              fa      <= held;
              held    <= 1'b0;
              run_q   <= 1'b1;
              pause_q <= 1'b0;
            end
          end
          S_RUN, S_FAST: begin
            if (bus.pause_toggle) begin
              state   <= S_PAUSE;
              held    <= (state == S_FAST);
              run_q   <= 1'b0;
              pause_q <= 1'b1;
            end else begin
              if (base_pulse) begin
                presc <= '0;
                phase <= phase_inc;
                t8    <= phase_inc[0];
                t2    <= (phase_inc[2:0] == 3'd7);
                t1    <= (phase_inc == 4'd15);
                t4    <= (phase_inc[1:0] == 2'd3) || ((state == S_FAST) && phase_inc[0]);
`ifdef LEVEL_OUT_EN
                l2    <= phase_inc[2];
                l4    <= phase_inc[1];
                l8    <= phase_inc[0];
`endif
              end else begin
                presc <= presc + PW'(1);
              end
              // t1 here is the tick currently on the output.
              if (bus.item_faster_grant) begin
                state  <= S_FAST;
                remain <= 4'(ITEM_SECS);
                fa     <= 1'b1;
              end else if ((state == S_FAST) && t1) begin
                remain <= remain - 4'd1;
                if (remain == 4'd1) begin
                  state <= S_RUN;
                  fa    <= 1'b0;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tick_2Hz      = t2;
  assign bus.tick_4Hz      = t4;
  assign bus.tick_8Hz      = t8;
  assign bus.tick_1Hz      = t1;
  assign bus.faster_active = fa;
  assign bus.faster_remain = remain;
  assign bus.running       = run_q;
  assign bus.paused        = pause_q;
`ifdef LEVEL_OUT_EN
  assign bus.lvl_2Hz       = l2;
  assign bus.lvl_4Hz       = l4;
  assign bus.lvl_8Hz       = l8;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed scenarios plus random event pulses,
// checked every cycle against a model based on total counted cycles.
module tb_tick_scheduler;

  localparam int BASE_DIV  = 4;
  localparam int ITEM_SECS = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAST  = 2;
  localparam int M_PAUSE = 3;

  logic clk;
  logic rst;

  tick_scheduler_if bus ();

  tick_scheduler #(.BASE_DIV(BASE_DIV), .ITEM_SECS(ITEM_SECS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_mode   = M_IDLE;
  int m_cnt    = 0;
  bit m_held   = 1'b0;
  int m_remain = 0;
  bit e1 = 1'b0, e2 = 1'b0, e4 = 1'b0, e8 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Phase is just the number of completed base periods since start.
  task automatic model_step(input bit r, input bit st, input bit sp, input bit pt, input bit gr);
    bit p1;
    int ph;
    p1 = e1;
    e1 = 1'b0; e2 = 1'b0; e4 = 1'b0; e8 = 1'b0;
    if (r || sp) begin
      m_mode = M_IDLE; m_cnt = 0; m_held = 1'b0; m_remain = 0;
    end else if (m_mode == M_IDLE) begin
      if (st) begin m_mode = M_RUN; m_cnt = 0; end
    end else if (m_mode == M_PAUSE) begin
      if (pt) begin m_mode = m_held ? M_FAST : M_RUN; m_held = 1'b0; end
    end else if (pt) begin
      m_held = (m_mode == M_FAST);
      m_mode = M_PAUSE;
    end else begin
      m_cnt++;
      if (m_cnt % BASE_DIV == 0) begin
        ph = (m_cnt / BASE_DIV) % 16;
        e8 = (ph % 2 == 1);
        e2 = (ph % 8 == 7);
        e1 = (ph == 15);
        e4 = (ph % 4 == 3) || ((m_mode == M_FAST) && (ph % 2 == 1));
      end
      if (gr) begin
        m_mode = M_FAST; m_remain = ITEM_SECS;
      end else if ((m_mode == M_FAST) && p1) begin
        m_remain--;
        if (m_remain == 0) m_mode = M_RUN;
      end
    end
  endtask

  task automatic compare_all();
    int ph;
    ph = (m_cnt / BASE_DIV) % 16;
    chk("ticks_1_2_4_8", 32'({bus.tick_1Hz, bus.tick_2Hz, bus.tick_4Hz, bus.tick_8Hz}),
        32'({e1, e2, e4, e8}));
    chk("faster_active", 32'(bus.faster_active),
        32'((m_mode == M_FAST) || ((m_mode == M_PAUSE) && m_held)));
    chk("faster_remain", 32'(bus.faster_remain), m_remain);
    chk("running", 32'(bus.running), 32'((m_mode == M_RUN) || (m_mode == M_FAST)));
    chk("paused", 32'(bus.paused), 32'(m_mode == M_PAUSE));
`ifdef LEVEL_OUT_EN
    chk("lvl_2_4_8", 32'({bus.lvl_2Hz, bus.lvl_4Hz, bus.lvl_8Hz}), ph % 8);
`endif
  endtask

  // One clock: drive at negedge, predict, compare at next negedge.
  task automatic cyc(input bit r, input bit st, input bit sp, input bit pt, input bit gr);
    rst = r;
    bus.start = st;
    bus.stop = sp;
    bus.pause_toggle = pt;
    bus.item_faster_grant = gr;
    model_step(r, st, sp, pt, gr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.item_faster_grant = 1'b0;
    @(negedge clk);

    // reset
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(5);

    // start and plain RUN cadence
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(130);

    // faster power-up through its full duration and back to RUN
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(260);

    // pause mid-FAST at remain=2, grants ignored while paused
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_mode == M_FAST && m_remain == 2) found = 1'b1;
      else idle_cycles(1);
    end
    chk("wait_remain2", 32'(found), 32'd1);
    idle_cycles(10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(40);

    // grant coinciding with the expiring 1 Hz tick
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_mode == M_FAST && m_remain == 1 && e1) begin
        found = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        idle_cycles(1);
      end
    end
    chk("wait_expiry", 32'(found), 32'd1);
    chk("remain_after_reload", 32'(bus.faster_remain), 32'(ITEM_SECS));
    idle_cycles(20);

    // stop during FAST, restart, reset mid-count, silence until next start
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(23);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(70);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(40);

    // random event pulses
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 399) == 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 79) == 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
